// File: rtl/hex_ascii_streamer.sv
// Streams a WIDTH-bit value as ASCII hex characters, most-significant digit first.
// Optional build macro HEX_ASCII_STREAMER_CRLF_EN appends CR (0x0D) and LF (0x0A) after the digits.
module hex_ascii_streamer #(
   parameter int WIDTH     = 16,
   parameter bit LOWERCASE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_value,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       out_char,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy
);

   localparam int DIGITS = (WIDTH + 3) / 4;
   localparam int VW     = DIGITS * 4;
`ifdef HEX_ASCII_STREAMER_CRLF_EN
   localparam int SEQ_LEN = DIGITS + 2;
`else
   localparam int SEQ_LEN = DIGITS;
`endif
   localparam int CW_RAW = $clog2(DIGITS + 2);
   localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
   localparam logic [CW-1:0] LAST_IDX = CW'(SEQ_LEN - 1);

   typedef enum logic {S_IDLE, S_EMIT} state_t;

   state_t        r_state;
   logic [VW-1:0] r_value;
   logic [CW-1:0] r_cnt;
   logic [7:0]    r_char;
   logic          r_in_ready;
   logic          r_out_valid;
   logic          r_out_last;
   logic          r_busy;

   logic [VW-1:0] w_ext;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_xfer;

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      if (nib < 4'd10) return 8'h30 + 8'(nib);
      return 8'(nib) + (LOWERCASE ? 8'h57 : 8'h37);
   endfunction

   // Character at sequence position idx: hex digits first, then the optional line ending.
   function automatic logic [7:0] char_at(input logic [VW-1:0] v, input logic [CW-1:0] idx);
      logic [VW-1:0] sh;
      if (int'(idx) < DIGITS) begin
         sh = v >> (4 * (DIGITS - 1 - int'(idx)));
         return hex_char(sh[3:0]);
      end
`ifdef HEX_ASCII_STREAMER_CRLF_EN
      if (int'(idx) == DIGITS) return 8'h0D;
      return 8'h0A;
`else
      return 8'h00;
`endif
   endfunction

   always_comb begin
      w_ext              = '0;
      w_ext[WIDTH-1:0]   = in_value;
      w_xfer             = r_out_valid && out_ready;
      w_cnt_nxt          = r_cnt + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_char      <= 8'h00;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_value     <= w_ext;
                  r_cnt       <= '0;
                  r_char      <= char_at(w_ext, '0);
                  r_out_last  <= (SEQ_LEN == 1);
                  r_out_valid <= 1'b1;
                  r_in_ready  <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (w_xfer) begin
                  if (r_out_last) begin
                     r_state     <= S_IDLE;
                     r_cnt       <= '0;
                     r_char      <= 8'h00;
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_in_ready  <= 1'b1;
                     r_busy      <= 1'b0;
                  end else begin
                     r_cnt      <= w_cnt_nxt;
                     r_char     <= char_at(r_value, w_cnt_nxt);
                     r_out_last <= (w_cnt_nxt == LAST_IDX);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_char  = r_char;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign busy      = r_busy;

endmodule
